// File: rtl/sifh_window_calc_if.sv
// Handshake bundle between the pixel channels / fine-histogram controller
// and the window calculator. The slave view is the calculator itself.
interface sifh_window_calc_if #(
  parameter int NB  = 5,
  parameter int NP  = 12,
  parameter int NCH = 4,
  parameter int IDW = (NCH > 1) ? $clog2(NCH) : 1
) ();
  // Channel side
  logic [NCH*NB-1:0] peak_ch;
  logic [NCH-1:0]    peak_valid;
  logic [NCH-1:0]    peak_ready;
  // Result side
  logic              out_valid;
  logic              out_ready;
  logic [IDW-1:0]    out_id;
  logic [NP-1:0]     th_minus;
  logic [NP-1:0]     th_plus;
  logic [NP-1:0]     delta;
  logic              clamp_lo;
  logic              clamp_hi;

  modport slave (
    input  peak_ch, peak_valid, out_ready,
    output peak_ready, out_valid, out_id, th_minus, th_plus, delta,
           clamp_lo, clamp_hi
  );

  modport master (
    output peak_ch, peak_valid, out_ready,
    input  peak_ready, out_valid, out_id, th_minus, th_plus, delta,
           clamp_lo, clamp_hi
  );
endinterface

// File: rtl/sifh_window_calc.sv
// SiFH peak-to-window stage: round-robin pick of one coarse peak per cycle,
// then a 2-stage pipeline producing the fine window and next-pass step.
module sifh_window_calc #(
  parameter int NB   = 5,
  parameter int NP   = 12,
  parameter int NCH  = 4,
  parameter int SB   = 3 << (NB - 2),
  parameter int WRAP = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sifh_window_calc_if.slave    bus
);
  localparam int IDW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int MAXI = (1 << NP) - 1;
  localparam int DRAW = (2 * SB) >> NB;
  localparam logic [NP-1:0] DELTA   = NP'((DRAW < 1) ? 1 : DRAW);
  localparam logic [NP-1:0] SB_N    = NP'(SB);
  localparam logic [NP-1:0] TWO_SB  = NP'(2 * SB);
  localparam logic [NP-1:0] MAX_N   = NP'(MAXI);
  localparam logic [NP-1:0] HI_EDGE = NP'(MAXI - SB);
  localparam logic [NP-1:0] MAX_M2  = NP'(MAXI - 2 * SB);
  localparam logic [NP:0]   SB_X    = (NP+1)'(SB);

  // ---------------- arbiter ----------------
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] gidx;
  logic [NCH-1:0] grant;
  logic           found, stall, xfer;
  logic [NB-1:0]  peak_sel;

  // pipeline state: vld_pipe_q[1] = stage 1, vld_pipe_q[2] = output slot
  logic [2:1]     vld_pipe_q, vld_pipe_d;
  logic [IDW-1:0] s1_id_q, s1_id_d;
  logic [NP-1:0]  s1_ch_q, s1_ch_d;
  logic [IDW-1:0] id_q, id_d;
  logic [NP-1:0]  tm_q, tm_d, tp_q, tp_d, dl_q, dl_d;
  logic           clo_q, clo_d, chi_q, chi_d;
  logic [NP-1:0]  tm_c, tp_c;
  logic           clo_c, chi_c;

  assign stall = vld_pipe_q[2] & ~bus.out_ready;

  // First requesting channel at or after the pointer, wrapping around
  always_comb begin
    int idx;
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NCH; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NCH) idx = idx - NCH;
      if (!found && bus.peak_valid[idx]) begin
        grant[idx] = 1'b1;
        gidx       = IDW'(idx);
        found      = 1'b1;
      end
    end
  end

  assign bus.peak_ready = grant & {NCH{~stall}};
  assign xfer           = found & ~stall;
  assign peak_sel       = bus.peak_ch[int'(gidx)*NB +: NB];

  // Pointer moves past the winner only when a transfer really happens
  always_comb begin
    ptr_d = ptr_q;
    if (xfer) ptr_d = (int'(gidx) == NCH - 1) ? '0 : gidx + 1'b1;
  end

  // ---------------- window arithmetic (stage 2 combinational) ----------------
  generate
    if (WRAP != 0) begin : g_wrap
      logic [NP:0] ch_x, lo_x, hi_x;
      assign ch_x = {1'b0, s1_ch_q};
      assign lo_x = ch_x - SB_X;
      assign hi_x = ch_x + SB_X;
      // Modular window; the extra top bit reports the borrow / carry
      always_comb begin
        tm_c  = lo_x[NP-1:0];
        tp_c  = hi_x[NP-1:0];
        clo_c = lo_x[NP];
        chi_c = hi_x[NP];
      end
    end else begin : g_clamp
      // Window pinned to a full 2*SB width against whichever edge it hits
      always_comb begin
        tm_c  = s1_ch_q - SB_N;
        tp_c  = s1_ch_q + SB_N;
        clo_c = 1'b0;
        chi_c = 1'b0;
        if (s1_ch_q <= SB_N) begin
          tm_c  = '0;
          tp_c  = TWO_SB;
          clo_c = 1'b1;
        end else if (s1_ch_q >= HI_EDGE) begin
          tm_c  = MAX_M2;
          tp_c  = MAX_N;
          chi_c = 1'b1;
        end
      end
    end
  endgenerate

  // Both stages advance together unless the output slot is blocked
  always_comb begin
    vld_pipe_d = vld_pipe_q;
    s1_id_d    = s1_id_q;
    s1_ch_d    = s1_ch_q;
    id_d       = id_q;
    tm_d       = tm_q;
    tp_d       = tp_q;
    dl_d       = dl_q;
    clo_d      = clo_q;
    chi_d      = chi_q;
    if (!stall) begin
      vld_pipe_d[1] = xfer;
      vld_pipe_d[2] = vld_pipe_q[1];
      if (xfer) begin
        s1_id_d = gidx;
        s1_ch_d = {peak_sel, {(NP-NB){1'b0}}};
      end
      if (vld_pipe_q[1]) begin
        id_d  = s1_id_q;
        tm_d  = tm_c;
        tp_d  = tp_c;
        dl_d  = DELTA;
        clo_d = clo_c;
        chi_d = chi_c;
      end
    end
  end

  // State registers; async reset drops everything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      vld_pipe_q <= '0;
      s1_id_q    <= '0;
      s1_ch_q    <= '0;
      id_q       <= '0;
      tm_q       <= '0;
      tp_q       <= '0;
      dl_q       <= '0;
      clo_q      <= 1'b0;
      chi_q      <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      vld_pipe_q <= vld_pipe_d;
      s1_id_q    <= s1_id_d;
      s1_ch_q    <= s1_ch_d;
      id_q       <= id_d;
      tm_q       <= tm_d;
      tp_q       <= tp_d;
      dl_q       <= dl_d;
      clo_q      <= clo_d;
      chi_q      <= chi_d;
    end
  end

  assign bus.out_valid = vld_pipe_q[2];
  assign bus.out_id    = id_q;
  assign bus.th_minus  = tm_q;
  assign bus.th_plus   = tp_q;
  assign bus.delta     = dl_q;
  assign bus.clamp_lo  = clo_q;
  assign bus.clamp_hi  = chi_q;
endmodule

// File: tb/tb_sifh_window_calc.sv
// Scoreboard bench: three instances (clamp SB=24, clamp SB=200, wrap SB=24)
// share the same stimulus; a negedge monitor checks arbitration, hold
// behaviour and every result against a plain-arithmetic reference.
module tb_sifh_window_calc;
  localparam int NB = 5, NP = 12, NCH = 4, MAXV = (1 << NP) - 1;

  typedef struct packed {
    logic        ov;
    logic [1:0]  id;
    logic [11:0] tm, tp, dl;
    logic        clo, chi;
    logic [3:0]  pr;
  } snap_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NCH-1:0]    pv;
  logic [NB-1:0]     pc [NCH];
  logic [NCH*NB-1:0] pcb;
  logic              ordy;
  logic [NCH-1:0]    xfer;

  always_comb begin
    pcb = '0;
    for (int i = 0; i < NCH; i++) pcb[i*NB +: NB] = pc[i];
  end

  sifh_window_calc_if #(.NB(NB), .NP(NP), .NCH(NCH)) if0 ();
  sifh_window_calc_if #(.NB(NB), .NP(NP), .NCH(NCH)) if1 ();
  sifh_window_calc_if #(.NB(NB), .NP(NP), .NCH(NCH)) if2 ();

  assign if0.peak_ch = pcb; assign if0.peak_valid = pv; assign if0.out_ready = ordy;
  assign if1.peak_ch = pcb; assign if1.peak_valid = pv; assign if1.out_ready = ordy;
  assign if2.peak_ch = pcb; assign if2.peak_valid = pv; assign if2.out_ready = ordy;

  sifh_window_calc #(.NB(NB), .NP(NP), .NCH(NCH), .SB(24),  .WRAP(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  sifh_window_calc #(.NB(NB), .NP(NP), .NCH(NCH), .SB(200), .WRAP(0)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  sifh_window_calc #(.NB(NB), .NP(NP), .NCH(NCH), .SB(24),  .WRAP(1)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  snap_t sn [3];
  assign sn[0] = {if0.out_valid, if0.out_id, if0.th_minus, if0.th_plus, if0.delta, if0.clamp_lo, if0.clamp_hi, if0.peak_ready};
  assign sn[1] = {if1.out_valid, if1.out_id, if1.th_minus, if1.th_plus, if1.delta, if1.clamp_lo, if1.clamp_hi, if1.peak_ready};
  assign sn[2] = {if2.out_valid, if2.out_id, if2.th_minus, if2.th_plus, if2.delta, if2.clamp_lo, if2.clamp_hi, if2.peak_ready};

  int passed = 0, total = 0;
  int q_id [3][$];
  int q_pk [3][$];
  int oid_log [$];

  function automatic int sb_of(input int k);   return (k == 1) ? 200 : 24; endfunction
  function automatic bit wrap_of(input int k); return k == 2;              endfunction

  task automatic chk(input string nm, input int k, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s dut%0d: got %0d expected %0d (t=%0t)", nm, k, act, exp, $time);
  endtask

  // Reference: window from the coarse peak by plain integer arithmetic
  function automatic void model(input int pk, input int sb, input bit wr,
                                output int tm, output int tp, output int dl,
                                output int clo, output int chi);
    int ch;
    ch = pk * (1 << (NP - NB));
    clo = 0; chi = 0;
    if (wr) begin
      tm = ch - sb; tp = ch + sb;
      if (tm < 0)    begin tm += MAXV + 1; clo = 1; end
      if (tp > MAXV) begin tp -= MAXV + 1; chi = 1; end
    end else if (ch <= sb) begin
      tm = 0; tp = 2 * sb; clo = 1;
    end else if (ch >= MAXV - sb) begin
      tp = MAXV; tm = MAXV - 2 * sb; chi = 1;
    end else begin
      tm = ch - sb; tp = ch + sb;
    end
    dl = (2 * sb) / (1 << NB);
    if (dl < 1) dl = 1;
  endfunction

  // Monitor / scoreboard
  int    last;
  snap_t prev [3];
  bit    stl_prev [3];
  always @(negedge clk) begin
    int g, c, id, pk, tm, tp, dl, clo, chi;
    bit stl;
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        q_id[k].delete(); q_pk[k].delete(); stl_prev[k] = 0;
      end
      last = NCH - 1;
      xfer = '0;
    end else begin
      g = -1;
      for (int j = 1; j <= NCH; j++) begin
        c = (last + j) % NCH;
        if (g < 0 && pv[c]) g = c;
      end
      for (int k = 0; k < 3; k++) begin
        stl = sn[k].ov & ~ordy;
        if (stl_prev[k]) chk("hold_outputs", k, longint'(sn[k] >> 4), longint'(prev[k] >> 4));
        chk("peak_ready", k, sn[k].pr, (stl || g < 0) ? 0 : (1 << g));
        if (sn[k].ov && ordy) begin
          chk("valid_expected", k, q_id[k].size() > 0, 1);
          if (q_id[k].size() > 0) begin
            id = q_id[k].pop_front(); pk = q_pk[k].pop_front();
            model(pk, sb_of(k), wrap_of(k), tm, tp, dl, clo, chi);
            chk("out_id",   k, sn[k].id,  id);
            chk("th_minus", k, sn[k].tm,  tm);
            chk("th_plus",  k, sn[k].tp,  tp);
            chk("delta",    k, sn[k].dl,  dl);
            chk("clamp_lo", k, sn[k].clo, clo);
            chk("clamp_hi", k, sn[k].chi, chi);
            if (k == 0) oid_log.push_back(int'(sn[0].id));
          end
        end
        if (g >= 0 && !stl) begin
          q_id[k].push_back(g); q_pk[k].push_back(int'(pc[g]));
        end
        prev[k] = sn[k]; stl_prev[k] = stl;
      end
      if (g >= 0 && !(sn[0].ov & ~ordy)) last = g;
      xfer = sn[0].pr & pv;
    end
  end

  task automatic step();
    @(posedge clk); #1;
    pv = pv & ~xfer;
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while (pv != 0 && n < maxc) begin step(); n++; end
    if (pv != 0) chk("drain_timeout", 0, pv, 0);
    repeat (4) step();
  endtask

  // Single transfer with latency checks; entered and left at posedge+1
  task automatic send_one(input int ch, input int pk);
    pc[ch] = NB'(pk); pv[ch] = 1'b1;
    @(negedge clk); chk("lat_ready", 0, if0.peak_ready[ch], 1);
    step();
    @(negedge clk); chk("lat_stage1", 0, if0.out_valid, 0);
    @(negedge clk); chk("lat_out", 0, if0.out_valid, 1);
    @(posedge clk); #1;
  endtask

  task automatic check_order(input int e0, input int e1, input int e2, input int e3, input int n);
    int ex [4];
    ex = '{e0, e1, e2, e3};
    chk("order_len", 0, oid_log.size(), n);
    for (int i = 0; i < n && i < oid_log.size(); i++) chk("order", 0, oid_log[i], ex[i]);
    oid_log.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; pv = '0; ordy = 1'b1;
    for (int i = 0; i < NCH; i++) pc[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) chk("reset_state", k, longint'(sn[k]), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    step();

    // centre, low edge, high edge (and the SB=200 / wrap variants)
    send_one(0, 10);
    send_one(0, 0);
    send_one(0, 31);
    send_one(3, 17);
    repeat (2) step();
    oid_log.delete();

    // all four at once from pointer 0, then from pointer 2
    pc[0] = 5'd7; pc[1] = 5'd13; pc[2] = 5'd22; pc[3] = 5'd29; pv = 4'hF;
    drain(20);
    check_order(0, 1, 2, 3, 4);
    send_one(1, 9);
    repeat (2) step();
    oid_log.delete();
    pc[0] = 5'd1; pc[1] = 5'd30; pc[2] = 5'd15; pc[3] = 5'd3; pv = 4'hF;
    drain(20);
    check_order(2, 3, 0, 1, 4);

    // backpressure with three pending channels
    pc[0] = 5'd4; pc[1] = 5'd27; pc[2] = 5'd31; pv = 4'b0111; ordy = 1'b0;
    repeat (7) step();
    @(negedge clk);
    chk("stall_ready", 0, if0.peak_ready, 0);
    chk("stall_valid", 0, if0.out_valid, 1);
    @(posedge clk); #1;
    ordy = 1'b1;
    drain(20);
    check_order(2, 0, 1, 0, 3);

    // reset with two results in flight
    pc[0] = 5'd11; pc[1] = 5'd12; pv = 4'b0011;
    step(); step();
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) chk("async_reset", k, longint'(sn[k]), 0);
    pv = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) chk("no_stale_valid", k, sn[k].ov, 0);
    end
    @(posedge clk); #1;
    oid_log.delete();

    // randomized traffic with random backpressure
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < NCH; i++)
        if (xfer[i] || !pv[i]) begin
          pv[i] = ($urandom_range(0, 2) != 0);
          pc[i] = NB'($urandom_range(0, 31));
        end
      ordy = ($urandom_range(0, 3) != 0);
    end
    ordy = 1'b1;
    drain(40);
    for (int k = 0; k < 3; k++) chk("scoreboard_empty", k, q_id[k].size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
